uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the line bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, integer-truncated, with a minimum of 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9, meaning payload bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, power of two and at least 2, meaning receive buffer entries.
REQ-006 SHALL have port CLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port RESET, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port RXD, input, 1 bit, asynchronous serial line that idles high.
REQ-009 SHALL have port rx_data, output, DATA_BITS wide, the byte at the FIFO head.
REQ-010 SHALL have port rx_valid, output, 1 bit, high when the FIFO is not empty.
REQ-011 SHALL have port rx_ready, input, 1 bit, consumer pop request.
REQ-012 SHALL have port frame_err, output, 1 bit, one-cycle pulse when a bad stop bit is seen.
REQ-013 SHALL have port parity_err, output, 1 bit, one-cycle pulse on a parity mismatch.
REQ-014 SHALL have port overrun, output, 1 bit, one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-015 SHALL pass RXD through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized value.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-017 In IDLE, SHALL move to START on a synchronized 1-to-0 transition and clear the bit counter.
REQ-018 In START, SHALL sample at CLKS_PER_BIT/2 clocks after the edge: if low, go to DATA; if high, treat as a glitch and return to IDLE with no error pulse.
REQ-019 In DATA, SHALL sample every CLKS_PER_BIT clocks after the START sample, shifting LSB first, for DATA_BITS samples.
REQ-020 After DATA, SHALL go to PARITY, or straight to STOP when PARITY = 0.
REQ-021 In PARITY, SHALL take one sample and check it against the data: odd means the total count of ones in data plus parity is odd; even means it is even.
REQ-022 In STOP, SHALL take one sample.
REQ-023 If the stop sample is 1 and parity is OK, SHALL push the frame on the following clock.
REQ-024 If the stop sample is 0, SHALL pulse frame_err, discard the frame and go to BREAK.
REQ-025 If the stop sample is 1 and parity is bad, SHALL pulse parity_err, discard the frame and go to IDLE.
REQ-026 If the stop sample is 0 and parity is also bad, SHALL pulse only frame_err.
REQ-027 In BREAK, SHALL wait for synchronized RXD = 1 and then go to IDLE, so that a held-low line produces exactly one frame_err.
REQ-028 After a good stop sample, SHALL enter IDLE immediately, so that back-to-back frames with a single stop bit are received without loss.
REQ-029 The FIFO SHALL be show-ahead: rx_data is the head entry whenever rx_valid = 1; rx_data is don't-care when rx_valid = 0.
REQ-030 SHALL pop when rx_valid and rx_ready are both high; rx_ready with an empty FIFO has no effect.
REQ-031 A push into a full FIFO SHALL be accepted if a pop occurs in the same cycle.
REQ-032 Otherwise a push into a full FIFO SHALL drop the new frame, pulse overrun and leave the FIFO contents unchanged.
REQ-033 A simultaneous push and pop on an empty FIFO SHALL be impossible, because rx_valid is 0.
REQ-034 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 Full and empty SHALL be distinguished by a count register of width log2(FIFO_DEPTH)+1.
REQ-036 Latency from the mid-stop-bit sample clock to rx_valid = 1 on an empty FIFO SHALL be 2 clocks.
REQ-037 The error pulses SHALL be registered, exactly one cycle wide, and asserted on the clock after the deciding sample.

Reset
REQ-038 While RESET = 1 at a rising CLK edge, SHALL force: state IDLE, synchronizer flops to 1, FIFO count and pointers to 0, rx_valid 0, frame_err, parity_err and overrun 0, and bit/baud counters 0.
REQ-039 Reset asserted mid-frame SHALL abandon the frame with no push and no error pulse.
REQ-040 After RESET is released, SHALL require a fresh 1-to-0 edge before starting a new frame.
REQ-041 FIFO storage contents need not be reset.

Verification (CLK_FREQ_HZ = 1_000_000, BAUD_RATE = 100_000, so CLKS_PER_BIT = 10; DATA_BITS = 8; FIFO_DEPTH = 4)
REQ-042 Scenario, good frames: with PARITY = 0, rx_ready = 1, send 0x55 then 0xA3 back-to-back -> rx_valid pulses twice, rx_data = 0x55 then 0xA3, no error pulses.
REQ-043 Scenario, parity: with PARITY = 2, send 0x07 with parity bit 1 -> one byte 0x07 is received; then send 0x07 with parity bit 0 -> one parity_err pulse and nothing pushed.
REQ-044 Scenario, framing and break: send 0x3C with stop = 0, then hold RXD low for 50 clocks, then send 0x11 -> exactly one frame_err pulse, then 0x11 is received.
REQ-045 Scenario, overrun: with rx_ready = 0, send 0x01..0x05 -> count reaches 4 and overrun pulses once on the fifth frame; then draining gives 0x01, 0x02, 0x03, 0x04.
REQ-046 Scenario, glitch rejection: a 3-clock low pulse on idle RXD -> no state exit beyond START, no push and no error pulse.
REQ-047 Scenario, reset mid-frame: assert RESET for 1 clock at DATA bit 4 of 0xFF -> rx_valid = 0, no error pulse, and the next clean 0x42 frame is received.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM with optional parity,
// break detection and a show-ahead receive FIFO with overrun reporting.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int CPB_RAW = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CPB     = (CPB_RAW < 4) ? 4 : CPB_RAW;
    localparam int HALF    = CPB / 2;
    localparam int CW      = $clog2(CPB);
    localparam int BW      = $clog2(DATA_BITS + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int NW      = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 sync1_q, sync2_q, prev_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_ok_q, par_ok_d;
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [NW-1:0]        cnt_q;
    logic                 rxd_s, tick, half_tick, pop, full, wr_en;

    assign rxd_s     = sync2_q;
    assign tick      = (baud_q == CW'(CPB - 1));
    assign half_tick = (baud_q == CW'(HALF - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_ok_d = par_ok_q;
        push_d   = 1'b0;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (prev_q && !rxd_s) begin
                    state_d  = S_START;
                    bit_d    = '0;
                    par_ok_d = 1'b1;
                end
            end
            S_START: begin
                if (half_tick) begin
                    baud_d  = '0;
                    state_d = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    baud_d  = '0;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1))
                        state_d = (PARITY == 0) ? S_STOP : S_PARITY;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    baud_d   = '0;
                    par_ok_d = (((^shift_q) ^ rxd_s) == (PARITY == 1));
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    baud_d = '0;
                    if (!rxd_s) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else if (!par_ok_q) begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                baud_d = '0;
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            par_ok_q <= 1'b1;
            push_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            sync1_q  <= RXD;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            par_ok_q <= par_ok_d;
            push_q   <= push_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
        end
    end

    // Payload shift register carries no reset; it is only consumed after a full frame.
    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    assign pop   = rx_valid && rx_ready;
    assign full  = (cnt_q == NW'(FIFO_DEPTH));
    assign wr_en = push_q && (!full || pop);
    assign ovr_d = push_q && full && !pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (pop)   rd_q <= rd_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + NW'(1);
                2'b01:   cnt_q <= cnt_q - NW'(1);
                default: cnt_q <= cnt_q;
            endcase
            ovr_q <= ovr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_q] <= shift_q;
    end

    assign rx_data    = mem_q[rd_q];
    assign rx_valid   = (cnt_q != '0);
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx: one instance without parity, one with even
// parity, both scored against a frame-level model (expected byte queues and error counts).
module tb_uart_rx;
    localparam int CPB   = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd0 = 1'b1, rxd1 = 1'b1;
    logic       rdy0 = 1'b1, rdy1 = 1'b1;
    logic       rdy_fix0 = 1'b1, rdy_fix1 = 1'b1;
    logic       rand_rdy = 1'b0;
    logic [7:0] rdata0, rdata1;
    logic       rv0, rv1, fe0, fe1, pe0, pe1, ov0, ov1;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int c_fe[2] = '{0, 0};
    int c_pe[2] = '{0, 0};
    int c_ov[2] = '{0, 0};
    int e_fe[2] = '{0, 0};
    int e_pe[2] = '{0, 0};
    int e_ov[2] = '{0, 0};
    int rises0 = 0, rise0_cyc = 0, st0 = 0;
    logic rv0_d = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    uart_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
              .PARITY(0), .FIFO_DEPTH(DEPTH)) u_dut (
        .CLK(clk), .RESET(rst), .RXD(rxd0), .rx_data(rdata0), .rx_valid(rv0),
        .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

    uart_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
              .PARITY(2), .FIFO_DEPTH(DEPTH)) u_dut_p (
        .CLK(clk), .RESET(rst), .RXD(rxd1), .rx_data(rdata1), .rx_valid(rv1),
        .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Consumer handshake changes just after the active edge so it is stable at the sample point.
    always @(posedge clk) begin
        #1;
        rdy0 = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix0;
        rdy1 = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix1;
    end

    always @(negedge clk) begin
        if (fe0) c_fe[0]++;
        if (fe1) c_fe[1]++;
        if (pe0) c_pe[0]++;
        if (pe1) c_pe[1]++;
        if (ov0) c_ov[0]++;
        if (ov1) c_ov[1]++;
        if (rv0 && !rv0_d) begin
            rises0++;
            rise0_cyc = cyc;
        end
        rv0_d = rv0;
        if (rv0 && rdy0) begin
            if (q0.size() == 0) check("pop0_unexpected", 1, 0);
            else check("data0", int'(rdata0), int'(q0.pop_front()));
        end
        if (rv1 && rdy1) begin
            if (q1.size() == 0) check("pop1_unexpected", 1, 0);
            else check("data1", int'(rdata1), int'(q1.pop_front()));
        end
    end

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rxd0 = v;
        else rxd1 = v;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level model: what the receiver must do with a frame of the given quality.
    task automatic expect_frame(input int which, input logic [7:0] d, input bit par_ok, input bit stop_ok);
        int sz;
        sz = (which == 0) ? q0.size() : q1.size();
        if (!stop_ok) e_fe[which]++;
        else if (!par_ok) e_pe[which]++;
        else if (sz >= DEPTH) e_ov[which]++;
        else if (which == 0) q0.push_back(d);
        else q1.push_back(d);
    endtask

    // Instance 1 carries an even parity bit, optionally inverted.
    task automatic send(input int which, input logic [7:0] d, input bit bad_par, input logic stop);
        logic p;
        p = (^d) ^ bad_par;
        if (which == 0) st0 = cyc;
        drive(which, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(which, d[i], CPB);
        if (which == 1) drive(which, p, CPB);
        drive(which, stop, CPB);
    endtask

    task automatic check_errs(input int w);
        check($sformatf("frame_err_cnt%0d", w), c_fe[w], e_fe[w]);
        check($sformatf("parity_err_cnt%0d", w), c_pe[w], e_pe[w]);
        check($sformatf("overrun_cnt%0d", w), c_ov[w], e_ov[w]);
    endtask

    initial begin
        int r0, lat, w, kind, budget;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("reset_valid0", int'(rv0), 0);
        check("reset_valid1", int'(rv1), 0);
        check("reset_ferr0", int'(fe0), 0);
        check("reset_perr1", int'(pe1), 0);
        check("reset_ovr0", int'(ov0), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // back-to-back good frames
        r0 = rises0;
        expect_frame(0, 8'h55, 1, 1);
        expect_frame(0, 8'hA3, 1, 1);
        send(0, 8'h55, 0, 1'b1);
        send(0, 8'hA3, 0, 1'b1);
        drive(0, 1'b1, 20);
        check("b2b_valid_rises", rises0 - r0, 2);
        check("b2b_drained", q0.size(), 0);
        check_errs(0);

        // even parity: good, bad, then bad parity with bad stop
        expect_frame(1, 8'h07, 1, 1);
        send(1, 8'h07, 0, 1'b1);
        drive(1, 1'b1, 20);
        expect_frame(1, 8'h07, 0, 1);
        send(1, 8'h07, 1, 1'b1);
        drive(1, 1'b1, 20);
        check("par_drained", q1.size(), 0);
        check_errs(1);
        expect_frame(1, 8'h5A, 0, 0);
        send(1, 8'h5A, 1, 1'b0);
        drive(1, 1'b1, 20);
        check_errs(1);

        // framing error followed by a held-low line
        expect_frame(0, 8'h3C, 1, 0);
        send(0, 8'h3C, 0, 1'b0);
        drive(0, 1'b0, 50);
        drive(0, 1'b1, 20);
        expect_frame(0, 8'h11, 1, 1);
        send(0, 8'h11, 0, 1'b1);
        drive(0, 1'b1, 20);
        check("break_drained", q0.size(), 0);
        check_errs(0);

        // short glitch on idle line
        r0 = rises0;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 40);
        check("glitch_valid", int'(rv0), 0);
        check("glitch_no_push", rises0 - r0, 0);
        check_errs(0);

        // overrun with a stalled consumer, plus first-byte latency
        rdy_fix0 = 1'b0;
        drive(0, 1'b1, 3);
        for (int v = 1; v <= 5; v++) begin
            expect_frame(0, 8'(v), 1, 1);
            send(0, 8'(v), 0, 1'b1);
            drive(0, 1'b1, 5);
            if (v == 1) begin
                lat = rise0_cyc - st0;
                check("latency_window", int'(lat >= 97 && lat <= 102), 1);
            end
        end
        check("full_valid", int'(rv0), 1);
        check_errs(0);
        rdy_fix0 = 1'b1;
        drive(0, 1'b1, 20);
        check("ovr_drained", q0.size(), 0);
        check("ovr_empty_valid", int'(rv0), 0);

        // reset in the middle of data bit 4 of 0xFF
        drive(0, 1'b0, CPB);
        drive(0, 1'b1, 4 * CPB + 5);
        rst = 1'b1;
        drive(0, 1'b1, 1);
        rst = 1'b0;
        drive(0, 1'b1, 4 + 3 * CPB + CPB);
        drive(0, 1'b1, 10);
        check("rst_mid_valid", int'(rv0), 0);
        check_errs(0);
        expect_frame(0, 8'h42, 1, 1);
        send(0, 8'h42, 0, 1'b1);
        drive(0, 1'b1, 20);
        check("rst_next_drained", q0.size(), 0);

        // randomized traffic on both instances
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            w    = int'($urandom_range(0, 1));
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind == 7 || kind == 8) begin
                expect_frame(w, d, 1, 0);
                send(w, d, 0, 1'b0);
            end else if (kind == 9 && w == 1) begin
                expect_frame(w, d, 0, 1);
                send(w, d, 1, 1'b1);
            end else begin
                expect_frame(w, d, 1, 1);
                send(w, d, 0, 1'b1);
            end
            drive(w, 1'b1, int'($urandom_range(3, 20)));
        end
        rand_rdy = 1'b0;
        budget = 300;
        while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("rand_drained0", q0.size(), 0);
        check("rand_drained1", q1.size(), 0);
        check_errs(0);
        check_errs(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
